// File: rtl/md_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
// The master drives requests; the slave (md_unit) returns busy and HI/LO.
interface md_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// MIPS-style HI/LO multiply/divide unit with fixed multi-cycle latency.
// Define MD_UNIT_MADD_EN to enable the MADD/MSUB accumulate ops (6/7).
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  op_e  op_in;
  logic is_mult_op, is_div_op, accept, done;

  assign op_in = op_e'(bus.op);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    is_mult_op = 1'b0;
    is_div_op  = 1'b0;
    case (op_in)
      OP_MULT, OP_MULTU: is_mult_op = 1'b1;
`ifdef MD_UNIT_MADD_EN
      OP_MADD, OP_MSUB:  is_mult_op = 1'b1;
`endif
      OP_DIV, OP_DIVU:   is_div_op  = 1'b1;
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && bus.start && (is_mult_op || is_div_op);
  assign done   = (state == BUSY) && (cnt == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == BUSY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      cnt  <= is_mult_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      op_q <= op_in;
      a_q  <= bus.a;
      b_q  <= bus.b;
    end else if (state == BUSY) begin
      cnt  <= cnt - CNT_W'(1);
    end
  end

  // Results are evaluated from the latched operands; the busy window is the multicycle budget.
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      div_zero, div_ovf;
  logic signed [WIDTH-1:0]   div_b_s, quot_s, rem_s;
  logic        [WIDTH-1:0]   div_b_u, quot_u, rem_u;

  assign prod_s   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign div_zero = (b_q == '0);
  assign div_ovf  = (a_q == MOST_NEG) && (b_q == '1);

  // Substitute a divisor of 1 for the two cases whose results are overridden anyway.
  assign div_b_s = (div_zero || div_ovf) ? WIDTH'(1) : $signed(b_q);
  assign div_b_u = div_zero ? WIDTH'(1) : b_q;
  assign quot_s  = $signed(a_q) / div_b_s;
  assign rem_s   = $signed(a_q) % div_b_s;
  assign quot_u  = a_q / div_b_u;
  assign rem_u   = a_q % div_b_u;

  logic             res_we;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    res_we = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV: begin
        res_we = !div_zero;
        if (div_ovf) begin
          res_lo = a_q;
          res_hi = '0;
        end else begin
          res_lo = quot_s;
          res_hi = rem_s;
        end
      end
      OP_DIVU: begin
        res_we = !div_zero;
        res_lo = quot_u;
        res_hi = rem_u;
      end
`ifdef MD_UNIT_MADD_EN
      OP_MADD: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      end
      OP_MSUB: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      if (res_we) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else if ((state == IDLE) && bus.start) begin
      if (op_in == OP_MTHI) hi_q <= bus.a;
      if (op_in == OP_MTLO) lo_q <= bus.a;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit at default parameters.
// Expectations for ops 6/7 follow whether MD_UNIT_MADD_EN is defined.
module tb_md_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pre_hi;
    logic [W-1:0] pre_lo;
    int           exp_cycles;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic preset(input logic [W-1:0] h, input logic [W-1:0] l);
    issue(3'd4, h, '0);
    issue(3'd5, l, '0);
  endtask

  initial begin
    int cyc;
    int bad;

    vecs[0]  = '{"mult_neg1x2",  3'd0, 32'hFFFFFFFF, 32'h2,        32'h0,  32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{"multu_max_x2", 3'd1, 32'hFFFFFFFF, 32'h2,        32'h0,  32'h0,        5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"div_m7_2",     3'd2, 32'hFFFFFFF9, 32'h2,        32'h0,  32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_by_zero", 3'd3, 32'h7,        32'h0,        32'h11, 32'h11,       10, 32'h11,       32'h11};
    vecs[4]  = '{"div_ovf",      3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,        10, 32'h0,        32'h80000000};
    vecs[5]  = '{"mult_7_m3",    3'd0, 32'h7,        32'hFFFFFFFD, 32'h0,  32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6]  = '{"divu_100_7",   3'd3, 32'h64,       32'h7,        32'h0,  32'h0,        10, 32'h2,        32'hE};
    vecs[7]  = '{"div_7_m2",     3'd2, 32'h7,        32'hFFFFFFFE, 32'h0,  32'h0,        10, 32'h1,        32'hFFFFFFFD};
    vecs[8]  = '{"mult_min_sq",  3'd0, 32'h80000000, 32'h80000000, 32'h0,  32'h0,        5,  32'h40000000, 32'h0};
    vecs[9]  = '{"div_m8_m3",    3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'h0,  32'h0,        10, 32'hFFFFFFFE, 32'h2};
`ifdef MD_UNIT_MADD_EN
    vecs[10] = '{"madd_carry",   3'd6, 32'h1,        32'h1,        32'h0,  32'hFFFFFFFF, 5,  32'h1,        32'h0};
    vecs[11] = '{"msub_wrap",    3'd7, 32'h1,        32'h1,        32'h0,  32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFFF};
`else
    vecs[10] = '{"madd_noop",    3'd6, 32'h1,        32'h1,        32'h0,  32'hFFFFFFFF, 0,  32'h0,        32'hFFFFFFFF};
    vecs[11] = '{"msub_noop",    3'd7, 32'h1,        32'h1,        32'h0,  32'h0,        0,  32'h0,        32'h0};
`endif

    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    #12;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_hi",   64'(bus.hi),   64'd0);
    check("reset_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      preset(vecs[i].pre_hi, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      count_busy(cyc);
      check({vecs[i].name, "_cycles"}, 64'(cyc),    64'(vecs[i].exp_cycles));
      check({vecs[i].name, "_hi"},     64'(bus.hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, "_lo"},     64'(bus.lo), 64'(vecs[i].exp_lo));
    end

    // MTHI then MTLO back to back: each visible one cycle later, never busy.
    preset(32'h0, 32'h0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA;
    @(negedge clk);
    check("mthi_hi",   64'(bus.hi),   64'hAAAA);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    bus.op = 3'd5; bus.a = 32'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_lo",   64'(bus.lo),   64'h5555);
    check("mtlo_busy", 64'(bus.busy), 64'd0);

    // Starts during BUSY (MTHI and MULT) are ignored: no hi write, no restart.
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    cyc = bus.busy ? 1 : 0;
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234;
    @(negedge clk);
    if (bus.busy) cyc++;
    check("ignore_hi_mid", 64'(bus.hi), 64'hAAAA);
    bus.op = 3'd0; bus.a = 32'h3; bus.b = 32'h3;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("ignore_cycles", 64'(cyc),    64'd10);
    check("ignore_hi",     64'(bus.hi), 64'd0);
    check("ignore_lo",     64'(bus.lo), 64'h80000000);

    // Reset on the 4th busy cycle: immediate clear, nothing written afterwards.
    preset(32'h55, 32'h66);
    issue(3'd2, 32'hFFFFFFF9, 32'h2);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_hi",   64'(bus.hi),   64'd0);
    check("rst_mid_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) bad++;
    end
    check("post_reset_quiet", 64'(bad), 64'd0);

    // Start presented in the very first cycle after reset release.
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'h3; bus.b = 32'h5;
    @(negedge clk);
    bus.start = 1'b0;
    count_busy(cyc);
    check("first_start_cycles", 64'(cyc),    64'd5);
    check("first_start_hi",     64'(bus.hi), 64'd0);
    check("first_start_lo",     64'(bus.lo), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width (even, >=8).
REQ-002 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU/MADD/MSUB (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request valid this cycle.
REQ-007 SHALL have port op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-008 SHALL have port a  input  WIDTH  operand rs (MTHI/MTLO source).
REQ-009 SHALL have port b  input  WIDTH  operand rt.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port hi  output  WIDTH  HI register.
REQ-012 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-013 SHALL use a two-state FSM: IDLE, BUSY; cycle counter width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
REQ-014 SHALL, in IDLE with start=1 and op in {0,1,2,3,6,7 (6/7 per REQ-028)}, latch op/a/b and enter BUSY at that edge.
REQ-015 SHALL hold busy=1 for exactly MULT_CYCLES (mult ops) or DIV_CYCLES (div ops) consecutive cycles, starting the cycle after the start edge.
REQ-016 SHALL write hi/lo on the edge that ends BUSY; busy deasserts and new hi/lo are visible in the same cycle.
REQ-017 SHALL keep hi/lo at previous values throughout BUSY.
REQ-018 SHALL write hi<=a (MTHI) or lo<=a (MTLO) on the edge where start=1 in IDLE; busy stays 0.
REQ-019 SHALL ignore start of any op while BUSY (no latch, no counter restart, no hi/lo write); the stall controller guarantees this does not occur in correct programs.
REQ-020 MULT: {hi,lo} = signed a * signed b, 2*WIDTH-bit product; MULTU unsigned.
REQ-021 DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend a; DIVU unsigned.
REQ-022 SHALL, for divide by zero (b=0), complete the full DIV_CYCLES and leave hi/lo unchanged.
REQ-023 SHALL, for signed DIV with a = most-negative and b = -1, produce lo = a, hi = 0.
REQ-024 SHALL have no combinational path from start/op/a/b to busy, hi or lo.

Reset
REQ-025 SHALL, on reset assertion at any time including mid-BUSY, asynchronously force hi=0, lo=0, busy=0, counter=0, FSM=IDLE.
REQ-026 SHALL discard any in-flight operation on reset; no hi/lo write after reset release.
REQ-027 SHALL accept a start in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, when macro MD_UNIT_MADD_EN is defined, implement MADD: {hi,lo} <= {hi,lo} + signed a*b and MSUB: {hi,lo} <= {hi,lo} - signed a*b, 2*WIDTH-bit wrap-around, with MULT_CYCLES latency and {hi,lo} sampled at completion edge.
REQ-029 SHALL, when MD_UNIT_MADD_EN is not defined, treat op 6/7 as no-ops: no BUSY entry, hi/lo unchanged.

Verification
REQ-030 reset; start op=0 a=0xFFFFFFFF b=2 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; op=1 same operands -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-031 start op=2 a=-7 b=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; op=3 a=7 b=0 with hi=lo=0x11 -> after 10 cycles hi=lo=0x11.
REQ-032 op=2 a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; start op=4 a=0x1234 issued during BUSY -> ignored, hi not 0x1234.
REQ-033 op=4 a=0xAAAA then op=5 a=0x5555 on consecutive cycles in IDLE -> hi=0xAAAA next cycle, lo=0x5555 cycle after, busy never 1.
REQ-034 start op=2, assert reset on 4th busy cycle -> hi=lo=0 and busy=0 immediately, stay 0 after release until new start.
REQ-035 MD_UNIT_MADD_EN defined: hi=0 lo=0xFFFFFFFF, op=6 a=1 b=1 -> hi=1 lo=0; undefined: same stimulus -> busy=0, hi/lo unchanged.
